// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store sequencer between execute stage and data memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic              ReqWr,
    input  logic [2:0]        ReqMemOp,
    input  logic [31:0]       ReqWData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [31:0]       RspRData,
    output logic              RspErr,
    output logic              MemReqValid,
    input  logic              MemReqReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWr,
    output logic [3:0]        MemWMask,
    output logic [31:0]       MemWData,
    input  logic              MemRspValid,
    input  logic [31:0]       MemRData
);
    // state | meaning
    // IDLE  | ready for a new request
    // ISSUE | memory request presented, waiting for MemReqReady
    // WAIT  | memory accepted request, waiting for MemRspValid
    // RESP  | response presented, waiting for RspReady
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [2:0]        req_op;
    logic [31:0]       req_wdata;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              op_illegal;
    logic              misalign;
    logic              fault;
    logic [1:0]        ofs_in;
    logic [31:0]       ld_shift;
    logic [31:0]       ld_data;
    logic [3:0]        st_mask;
    logic [31:0]       st_data;

    // Latched offset is already naturally aligned, so the datapath never sees a misaligned lane.
    always_comb begin
        op_illegal = (ReqMemOp == 3'b011) || (ReqMemOp[2:1] == 2'b11) || (ReqWr && ReqMemOp[2]);
        misalign   = 1'b0;
        case (ReqMemOp[1:0])
            2'b01:   ofs_in = {ReqAddr[1], 1'b0};
            2'b10:   ofs_in = 2'b00;
            default: ofs_in = ReqAddr[1:0];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((ReqMemOp[1:0] == 2'b01) && ReqAddr[0]) ||
                   ((ReqMemOp[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
`endif
        fault = op_illegal || misalign;
    end

    always_comb begin
        ld_shift = MemRData >> {req_addr[1:0], 3'b000};
        case (req_op)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        case (req_op[1:0])
            2'b00: begin
                st_mask = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << req_addr[1:0];
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            req_addr  <= '0;
            req_wr    <= 1'b0;
            req_op    <= 3'd0;
            req_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_IDLE && ReqValid) begin
            req_addr  <= {ReqAddr[ADDR_W-1:2], ofs_in};
            req_wr    <= ReqWr;
            req_op    <= ReqMemOp;
            req_wdata <= ReqWData;
            rsp_rdata <= '0;
            rsp_err   <= fault;
        end else if (state == ST_WAIT && MemRspValid) begin
            rsp_rdata <= req_wr ? 32'd0 : ld_data;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ReqValid)    state_nxt = fault ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (MemReqReady) state_nxt = ST_WAIT;
            ST_WAIT:  if (MemRspValid) state_nxt = ST_RESP;
            ST_RESP:  if (RspReady)    state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Buses read as zero outside the state that qualifies them.
    always_comb begin
        ReqReady    = 1'b0;
        RspValid    = 1'b0;
        RspRData    = '0;
        RspErr      = 1'b0;
        MemReqValid = 1'b0;
        MemAddr     = '0;
        MemWr       = 1'b0;
        MemWMask    = 4'b0000;
        MemWData    = '0;
        case (state)
            ST_IDLE: ReqReady = 1'b1;
            ST_ISSUE: begin
                MemReqValid = 1'b1;
                MemAddr     = {req_addr[ADDR_W-1:2], 2'b00};
                MemWr       = req_wr;
                MemWMask    = req_wr ? st_mask : 4'b0000;
                MemWData    = req_wr ? st_data : 32'd0;
            end
            ST_RESP: begin
                RspValid = 1'b1;
                RspRData = rsp_rdata;
                RspErr   = rsp_err;
            end
            default: ;
        endcase
    end
endmodule
